tdm_demux_1x16: RTL

TDM_DEMUX_1X16 -- requirements
Module: tdm_demux_1x16

---
 rtl/tdm_demux_1x16.sv | 108 ++++++++++
 1 files changed

// File: rtl/tdm_demux_1x16.sv
// 1-to-16 TDM serial demultiplexer with auto round-robin and addressed modes.
// Optional even-parity frame trailer enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux_1x16 #(
  parameter int HOLD_OUTPUTS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  input  logic        frame_start,
  input  logic        mode,
  input  logic [3:0]  sel,
  output logic [15:0] dout,
  output logic [15:0] dout_stb,
  output logic [3:0]  chan,
  output logic        frame_done
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic        parity_err
`endif
);

  logic [15:0] dout_q, dout_d;
  logic [15:0] stb_q, stb_d;
  logic [3:0]  chan_q, chan_d;
  logic        fd_q, fd_d;
  logic [3:0]  tgt;
  logic        wr;

`ifdef TDM_DEMUX_PARITY_EN
  typedef enum logic {DATA, PARITY} state_t;
  state_t state_q, state_d;
  logic   perr_q, perr_d;
  logic   acc_q, acc_d;
`endif

  always_comb begin
    dout_d = (HOLD_OUTPUTS != 0) ? dout_q : '0;
    stb_d  = '0;
    chan_d = chan_q;
    fd_d   = 1'b0;
    wr     = 1'b0;
    tgt    = mode ? sel : (frame_start ? 4'd0 : chan_q);
`ifdef TDM_DEMUX_PARITY_EN
    state_d = state_q;
    perr_d  = perr_q;
    acc_d   = acc_q;
`endif
    if (din_valid) begin
      wr = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
      // Trailer bit: checked against the running XOR, never written out
      if (!mode && state_q == PARITY && !frame_start) begin
        wr      = 1'b0;
        perr_d  = acc_q ^ din;
        fd_d    = 1'b1;
        state_d = DATA;
      end else if (!mode) begin
        acc_d   = (tgt == 4'd0) ? din : (acc_q ^ din);
        state_d = (tgt == 4'd15) ? PARITY : DATA;
      end
`endif
      if (wr) begin
        dout_d[tgt] = din;
        stb_d[tgt]  = 1'b1;
        if (!mode) begin
          chan_d = tgt + 4'd1;
`ifndef TDM_DEMUX_PARITY_EN
          fd_d   = (tgt == 4'd15);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      stb_q   <= '0;
      chan_q  <= '0;
      fd_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      state_q <= DATA;
      perr_q  <= 1'b0;
      acc_q   <= 1'b0;
`endif
    end else begin
      dout_q  <= dout_d;
      stb_q   <= stb_d;
      chan_q  <= chan_d;
      fd_q    <= fd_d;
`ifdef TDM_DEMUX_PARITY_EN
      state_q <= state_d;
      perr_q  <= perr_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_stb   = stb_q;
  assign chan       = chan_q;
  assign frame_done = fd_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
